instruction_fetch_unit: RTL and testbench

- PC generator and fetch-stage controller sitting directly upstream of the 32-bit byte-addressed instruction memory.
- Drives the memory read address and tracks the one-cycle registered read latency.
- Presents an instruction/PC bundle with a valid bit to the decode (ID) stage.
- Handles decode stalls by replaying the in-flight address, and handles branch/jump redirects by flushing the wrong-path fetch.

---
 rtl/instruction_fetch_unit_if.sv | 43 ++++
 rtl/instruction_fetch_unit.sv | 93 +++++++++
 tb/tb_instruction_fetch_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decode bundle, redirect request and status.
// The master modport is the fetch unit; the slave modport is the memory/decode side.
interface instruction_fetch_unit_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_instruction;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        addr_fault;
  logic [31:0] fetch_count;

  modport master (
    output mem_addr,
    input  mem_instruction,
    input  id_stall,
    input  redirect_valid,
    input  redirect_target,
    output id_instr,
    output id_pc,
    output id_pc_plus4,
    output id_valid,
    output addr_fault,
    output fetch_count
  );

  modport slave (
    input  mem_addr,
    output mem_instruction,
    output id_stall,
    output redirect_valid,
    output redirect_target,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus4,
    input  id_valid,
    input  addr_fault,
    input  fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC generator and fetch controller in front of a one-cycle registered instruction memory.
// Stalls replay the in-flight address; redirects discard the wrong-path word.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 1024,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  instruction_fetch_unit_if.master bus
);

  localparam logic [31:0] ADDR_MASK  = 32'(IMEM_BYTES - 1);
  localparam logic [31:0] WORD_MASK  = ADDR_MASK & ~32'd3;
  localparam logic [31:0] RESET_ADDR = RESET_PC & ADDR_MASK;

  logic [31:0] pc_reg;
  logic [31:0] f_pc;
  logic        f_valid;
  logic        fault_reg;
  logic [31:0] count_reg;

  logic [31:0] pc_next;
  logic [31:0] f_pc_next;
  logic        f_valid_next;
  logic        fault_next;
  logic [31:0] count_next;

  logic [31:0] addr_sel;
  logic        target_bad;

  // Replaying f_pc while stalled keeps the memory output steady without a holding register.
  always_comb begin
    addr_sel = pc_reg;
    if (!rst_n && !bus.id_stall) begin
      addr_sel = RESET_ADDR;
    end else if (bus.id_stall) begin
      addr_sel = f_pc;
    end
  end

  assign bus.mem_addr = addr_sel & ADDR_MASK;

  assign target_bad = (bus.redirect_target[1:0] != 2'b00) ||
                      ((bus.redirect_target & ~ADDR_MASK) != 32'd0);

  always_comb begin
    pc_next      = pc_reg;
    f_pc_next    = f_pc;
    f_valid_next = f_valid;
    fault_next   = fault_reg;
    count_next   = count_reg;
    if (bus.redirect_valid) begin
      pc_next      = bus.redirect_target & WORD_MASK;
      f_pc_next    = bus.mem_addr;
      f_valid_next = 1'b0;
      if (target_bad) begin
        fault_next = 1'b1;
      end
    end else if (!bus.id_stall) begin
      pc_next      = (pc_reg + 32'd4) & ADDR_MASK;
      f_pc_next    = pc_reg;
      f_valid_next = 1'b1;
      if (f_valid) begin
        count_next = count_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg    <= RESET_ADDR;
      f_pc      <= RESET_ADDR;
      f_valid   <= 1'b0;
      fault_reg <= 1'b0;
      count_reg <= 32'd0;
    end else begin
      pc_reg    <= pc_next;
      f_pc      <= f_pc_next;
      f_valid   <= f_valid_next;
      fault_reg <= fault_next;
      count_reg <= count_next;
    end
  end

  assign bus.id_valid    = f_valid;
  assign bus.id_pc       = f_pc;
  assign bus.id_pc_plus4 = (f_pc + 32'd4) & ADDR_MASK;
  assign bus.id_instr    = f_valid ? bus.mem_instruction : NOP_INSTR;
  assign bus.addr_fault  = fault_reg;
  assign bus.fetch_count = count_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed walkthrough with literal
// expectations, then randomized traffic compared every cycle against a behavioural model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          IMEM_BYTES = 1024;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] MEM_SIZE   = 32'd1024;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .IMEM_BYTES(IMEM_BYTES),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: registered read, word-indexed.
  logic [31:0] imem [256];
  always @(posedge clk) bus.mem_instruction <= imem[bus.mem_addr[9:2]];

  // Behavioural model: what ID should be seeing, and where the fetcher goes next.
  bit          known = 1'b0;
  logic [31:0] m_next;
  logic [31:0] m_shown;
  bit          m_valid;
  bit          m_fault;
  logic [31:0] m_count;
  logic [31:0] m_presented;

  function automatic logic [31:0] expectedAddr();
    if (!rst_n && !bus.id_stall) return RESET_PC % MEM_SIZE;
    if (bus.id_stall) return m_shown;
    return m_next;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      known   = 1'b1;
      m_next  = RESET_PC % MEM_SIZE;
      m_shown = RESET_PC % MEM_SIZE;
      m_valid = 1'b0;
      m_fault = 1'b0;
      m_count = 32'd0;
    end else if (known) begin
      m_presented = expectedAddr();
      if (bus.redirect_valid) begin
        if (bus.redirect_target % 4 != 0 || bus.redirect_target >= MEM_SIZE) m_fault = 1'b1;
        m_shown = m_presented;
        m_valid = 1'b0;
        m_next  = ((bus.redirect_target / 4) * 4) % MEM_SIZE;
      end else if (!bus.id_stall) begin
        if (m_valid) m_count = m_count + 1;
        m_shown = m_next;
        m_valid = 1'b1;
        m_next  = (m_next + 4) % MEM_SIZE;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: every negedge once the model has seen a reset.
  always @(negedge clk) begin
    if (known) begin
      checkOutput("id_valid", 32'(bus.id_valid), 32'(m_valid));
      checkOutput("id_pc", bus.id_pc, m_shown);
      checkOutput("id_pc_plus4", bus.id_pc_plus4, (m_shown + 4) % MEM_SIZE);
      checkOutput("id_instr", bus.id_instr, m_valid ? imem[m_shown / 4] : NOP_INSTR);
      checkOutput("addr_fault", 32'(bus.addr_fault), 32'(m_fault));
      checkOutput("fetch_count", bus.fetch_count, m_count);
      checkOutput("mem_addr", bus.mem_addr, expectedAddr());
    end
  end

  // Waits for an edge, then drives the inputs seen by the following edge.
  task automatic applyStimulus(input bit rst, input bit stall, input bit redir, input logic [31:0] target);
    @(posedge clk);
    #2;
    rst_n               = rst;
    bus.id_stall        = stall;
    bus.redirect_valid  = redir;
    bus.redirect_target = target;
    #1;
  endtask

  initial begin
    bit          r, s, rv;
    logic [31:0] t;
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    rst_n               = 1'b0;
    bus.id_stall        = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'd0;

    applyStimulus(0, 0, 0, 0);
    checkOutput("lit_reset_valid", 32'(bus.id_valid), 32'd0);
    checkOutput("lit_reset_instr", bus.id_instr, NOP_INSTR);
    checkOutput("lit_reset_pc", bus.id_pc, 32'h0);
    checkOutput("lit_reset_pc4", bus.id_pc_plus4, 32'h4);
    checkOutput("lit_reset_count", bus.fetch_count, 32'd0);
    checkOutput("lit_reset_maddr", bus.mem_addr, 32'h0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("lit_first_bubble", 32'(bus.id_valid), 32'd0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("lit_w0_valid", 32'(bus.id_valid), 32'd1);
    checkOutput("lit_w0_instr", bus.id_instr, imem[0]);
    checkOutput("lit_w0_count", bus.fetch_count, 32'd0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("lit_w1_pc", bus.id_pc, 32'h4);
    checkOutput("lit_w1_instr", bus.id_instr, imem[1]);
    checkOutput("lit_w1_count", bus.fetch_count, 32'd1);
    applyStimulus(1, 1, 0, 0);
    checkOutput("lit_w2_pc", bus.id_pc, 32'h8);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 1, 0, 0);
      checkOutput("lit_stall_pc", bus.id_pc, 32'h8);
      checkOutput("lit_stall_instr", bus.id_instr, imem[2]);
      checkOutput("lit_stall_maddr", bus.mem_addr, 32'h8);
      checkOutput("lit_stall_count", bus.fetch_count, 32'd2);
    end
    applyStimulus(1, 0, 0, 0);
    checkOutput("lit_stall3_pc", bus.id_pc, 32'h8);
    applyStimulus(1, 0, 0, 0);
    checkOutput("lit_release_pc", bus.id_pc, 32'hC);
    checkOutput("lit_release_instr", bus.id_instr, imem[3]);
    checkOutput("lit_release_count", bus.fetch_count, 32'd3);

    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 1, 32'h40);
    checkOutput("lit_redir_src_pc", bus.id_pc, 32'h4);
    applyStimulus(1, 0, 0, 0);
    checkOutput("lit_redir_bubble", 32'(bus.id_valid), 32'd0);
    checkOutput("lit_redir_maddr", bus.mem_addr, 32'h40);
    applyStimulus(1, 0, 0, 0);
    checkOutput("lit_redir_pc", bus.id_pc, 32'h40);
    checkOutput("lit_redir_instr", bus.id_instr, imem[16]);
    checkOutput("lit_redir_fault", 32'(bus.addr_fault), 32'd0);

    applyStimulus(1, 1, 1, 32'h20);
    applyStimulus(1, 0, 0, 0);
    checkOutput("lit_rs_bubble", 32'(bus.id_valid), 32'd0);
    checkOutput("lit_rs_maddr", bus.mem_addr, 32'h20);
    applyStimulus(1, 0, 0, 0);
    checkOutput("lit_rs_pc", bus.id_pc, 32'h20);
    checkOutput("lit_rs_instr", bus.id_instr, imem[8]);

    applyStimulus(1, 0, 1, 32'h3FE);
    applyStimulus(1, 0, 0, 0);
    checkOutput("lit_mis_fault", 32'(bus.addr_fault), 32'd1);
    checkOutput("lit_mis_maddr", bus.mem_addr, 32'h3FC);
    applyStimulus(1, 0, 0, 0);
    checkOutput("lit_mis_pc", bus.id_pc, 32'h3FC);
    checkOutput("lit_mis_pc4", bus.id_pc_plus4, 32'h0);
    checkOutput("lit_mis_instr", bus.id_instr, imem[255]);
    applyStimulus(1, 0, 0, 0);
    checkOutput("lit_wrap_pc", bus.id_pc, 32'h0);
    checkOutput("lit_wrap_fault", 32'(bus.addr_fault), 32'd1);
    checkOutput("lit_wrap_count", bus.fetch_count, 32'd4);

    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("lit_pre_rst_count", bus.fetch_count, 32'd7);
    applyStimulus(1, 0, 0, 0);
    checkOutput("lit_rst_valid", 32'(bus.id_valid), 32'd0);
    checkOutput("lit_rst_count", bus.fetch_count, 32'd0);
    checkOutput("lit_rst_fault", 32'(bus.addr_fault), 32'd0);
    checkOutput("lit_rst_maddr", bus.mem_addr, RESET_PC);

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      s  = ($urandom_range(0, 99) < 25);
      rv = ($urandom_range(0, 99) < 10);
      case ($urandom_range(0, 3))
        0: t = 32'($urandom_range(0, 255)) * 32'd4;
        1: t = 32'($urandom_range(0, 1023));
        2: t = $urandom;
        default: t = 32'h3F8 + 32'($urandom_range(0, 7));
      endcase
      applyStimulus(r, s, rv, t);
    end
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
